uart_tx_fifo_brg: RTL and testbench
===================================

// Module: uart_tx_fifo_brg
// PURPOSE
//  Parametrised UART transmitter: integrated baud-rate generator (16x CE), holding FIFO, run-time framing control.
//  Successor to the fixed 8-bit single-THR UART_TXSM plus external 16x divider used to drive RD into M16C5x.
//  Adds pWidth data bits, pDepth FIFO, 1/2 stop bits, parity modes, CTS flow control and an RS-485 DE output.
//  Serves as a synthesizable SSP/UART TX channel and as the UART stimulus source in M16C5x benches.
// PARAMETERS
//  pWidth    8   data bits per frame, 5..9, sent LSB first
//  pDepth    16  FIFO depth in words, power of 2, 2..256
//  pBaudDiv  16  Clk cycles per CE_16x pulse, >=1; 29.4912 MHz / 16 = 16 x 115200 baud
// PORTS
//  Clk      in   1                   system clock, all logic on rising edge
//  nRst     in   1                   asynchronous active-low reset
//  WE       in   1                   FIFO write strobe; accepted only when FF=0
//  WD       in   pWidth              FIFO write data
//  FF       out  1                   FIFO full
//  EF       out  1                   FIFO empty
//  Cnt      out  log2(pDepth)+1      FIFO occupancy, 0..pDepth
//  OvErr    out  1                   1-cycle pulse when WE is asserted while FF=1
//  NumStop  in   1                   0 = 1 stop bit, 1 = 2 stop bits
//  ParEn    in   1                   parity bit enable
//  Par      in   2                   0 odd, 1 even, 2 space (0), 3 mark (1)
//  CTSi     in   1                   clear-to-send, active high, sampled only before a start bit
//  TxD      out  1                   serial output; idle/mark = 1
//  DE       out  1                   RS-485 driver enable, high from start bit through last stop bit
//  TxIdle   out  1                   FSM in IDLE
//  CE_16x   out  1                   internal 16x baud enable (observability)
// BEHAVIOUR
//  Reset (async, nRst=0):
//   - TxD=1, DE=0, TxIdle=1, EF=1, FF=0, Cnt=0, OvErr=0, CE_16x=0.
//   - FIFO pointers and BRG counter cleared; a frame in flight is aborted with no partial stop bit.
//  BRG:
//   - Down-counter loaded with pBaudDiv-1; CE_16x=1 for one Clk when it reaches 0, then it reloads.
//   - Free-runs from reset and is never synchronized to frames.
//  FIFO:
//   - Write when WE & ~FF. Pop is internal, one cycle, on entry to START.
//   - Simultaneous write and pop: Cnt unchanged, both take effect.
//   - WE while FF=1: data dropped, OvErr pulses, Cnt unchanged.
//   - Pointers wrap modulo pDepth. FF=(Cnt==pDepth), EF=(Cnt==0).
//  FSM (advances only on CE_16x; 4-bit tick counter, 16 ticks per bit):
//   - IDLE: on a CE_16x with ~EF & CTSi -> START. Pop head word into shift register.
//     Latch NumStop, ParEn and Par for the whole frame. Assert DE.
//   - START: TxD=0 for 16 ticks -> DATA.
//   - DATA: pWidth bits LSB first, 16 ticks each -> PAR if ParEn, else STOP.
//   - PAR: odd = ~^data, even = ^data, space = 0, mark = 1 -> STOP.
//   - STOP: TxD=1 for 16 ticks (32 if NumStop) -> START at once if ~EF & CTSi (no idle gap), else IDLE.
//   - DE falls on entry to IDLE.
//  Outputs:
//   - TxD and DE are registered.
//   - Start bit appears 1 Clk after the CE_16x that leaves IDLE.
//  Timing:
//   - Frame length in ticks = 16*(1+pWidth+ParEn+1+NumStop).
//   - Write-to-start-bit latency when idle: 2..pBaudDiv+2 Clk.
//  Flow control and config changes:
//   - CTSi falling mid-frame does not abort; it only blocks the next start.
//   - Framing input changes take effect at the next frame start.
// TESTING
//  - Reset: nRst=0 for 200 ns -> TxD=1, DE=0, EF=1, Cnt=0. Release -> CE_16x every 16 Clk.
//  - 8N1, write 0x55 -> TxD shows 0,1,0,1,0,1,0,1,0,1 at 256 Clk per bit. DE high for exactly 2560 Clk.
//  - Parity on 0x7B: even -> parity bit 0; odd -> 1; mark, NumStop=1 -> 1 then two stop bits, 3072-Clk frame.
//  - Burst of 13 bytes (FF,80,7B,...,31,00) -> back-to-back frames, no idle gap, TxIdle only after last.
//    A UART RX model recovers all 13 bytes in order.
//  - Overflow, CTSi=0: write 17 words, pDepth=16 -> FF=1, OvErr pulses once, Cnt=16.
//    Then CTSi=1 -> 16 frames sent, EF=1.
//  - CTSi low mid-frame completes the frame and holds the next. nRst low mid-DATA -> TxD=1, DE=0, FIFO empty.

Source files
------------

// File: rtl/uart_tx_fifo_brg_if.sv
// UART TX channel bundle: FIFO write side, framing controls, flow control and serial outputs.
// Master drives writes, framing and CTS; slave returns FIFO status, serial line and observability.
// Widths follow the data width and FIFO depth of the attached transmitter.
interface uart_tx_fifo_brg_if #(
  parameter int pWidth = 8,
  parameter int pDepth = 16
);
  logic                      WE;
  logic [pWidth-1:0]         WD;
  logic                      FF;
  logic                      EF;
  logic [$clog2(pDepth):0]   Cnt;
  logic                      OvErr;
  logic                      NumStop;
  logic                      ParEn;
  logic [1:0]                Par;
  logic                      CTSi;
  logic                      TxD;
  logic                      DE;
  logic                      TxIdle;
  logic                      CE_16x;

  modport master (
    output WE, WD, NumStop, ParEn, Par, CTSi,
    input  FF, EF, Cnt, OvErr, TxD, DE, TxIdle, CE_16x
  );

  modport slave (
    input  WE, WD, NumStop, ParEn, Par, CTSi,
    output FF, EF, Cnt, OvErr, TxD, DE, TxIdle, CE_16x
  );
endinterface

// File: rtl/uart_tx_fifo_brg.sv
// UART transmitter with free-running 16x baud generator, holding FIFO and per-frame framing latch.
// Latency: start bit 1 Clk after the CE_16x that leaves IDLE; TxD/DE registered.
// Backpressure: writes dropped (OvErr pulse) when full; CTSi low only holds the next frame start.
module uart_tx_fifo_brg #(
  parameter int pWidth   = 8,
  parameter int pDepth   = 16,
  parameter int pBaudDiv = 16
) (
  input logic              Clk,
  input logic              nRst,
  uart_tx_fifo_brg_if.slave tx
);

  localparam int PW = (pDepth > 1) ? $clog2(pDepth) : 1;
  localparam int CW = PW + 1;
  localparam int BW = (pBaudDiv > 1) ? $clog2(pBaudDiv) : 1;
  localparam logic [BW-1:0] BRG_RELOAD = BW'(pBaudDiv - 1);
  localparam logic [3:0]    LAST_BIT   = 4'(pWidth - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  // ---------------- baud-rate generator ----------------
  logic [BW-1:0] brg_q, brg_d;
  logic          ce_q;

  // Down-counter reloads after reaching zero; the enable is registered so it is low in reset.
  always_comb begin
    brg_d = (brg_q == '0) ? BRG_RELOAD : brg_q - 1'b1;
  end

  // CE_16x is high during exactly the cycle the counter sits at zero.
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      brg_q <= BRG_RELOAD;
      ce_q  <= 1'b0;
    end else begin
      brg_q <= brg_d;
      ce_q  <= (brg_d == '0);
    end
  end

  // ---------------- holding FIFO ----------------
  logic [pWidth-1:0] mem_q [pDepth];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     cnt_q;
  logic              ov_q;
  logic              full, empty, push, pop;
  logic [pWidth-1:0] head;

  assign full  = (cnt_q == CW'(pDepth));
  assign empty = (cnt_q == '0);
  assign push  = tx.WE & ~full;
  assign head  = mem_q[rd_ptr_q];

  // Storage array carries no reset; only pointers and count define validity.
  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr_q] <= tx.WD;
  end

  // Pointers wrap naturally (power-of-two depth); simultaneous push/pop leaves count unchanged.
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ov_q     <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      ov_q <= tx.WE & full;
    end
  end

  // ---------------- frame FSM ----------------
  logic [2:0]        state_q, state_d;
  logic [3:0]        tick_q, tick_d;
  logic [3:0]        bit_q, bit_d;
  logic              stop2_q, stop2_d;
  logic [pWidth-1:0] sh_q, sh_d;
  logic              par_en_q, par_en_d;
  logic              nstop_q, nstop_d;
  logic              par_bit_q, par_bit_d;
  logic              txd_q, txd_d;
  logic              de_q, de_d;
  logic              start_ok, load, par_calc;

  assign start_ok = ~empty & tx.CTSi;

  // Parity of the word about to be popped, using the mode latched with it.
  always_comb begin
    case (tx.Par)
      2'd0:    par_calc = ~^head;
      2'd1:    par_calc = ^head;
      2'd2:    par_calc = 1'b0;
      default: par_calc = 1'b1;
    endcase
  end

  // Next-state: everything moves only on CE_16x; each bit lasts 16 ticks.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    stop2_d   = stop2_q;
    sh_d      = sh_q;
    par_en_d  = par_en_q;
    nstop_d   = nstop_q;
    par_bit_d = par_bit_q;
    txd_d     = txd_q;
    de_d      = de_q;
    load      = 1'b0;
    if (ce_q) begin
      tick_d = tick_q + 4'd1;
      case (state_q)
        S_IDLE: begin
          tick_d = 4'd0;
          load   = start_ok;
        end
        S_START: begin
          if (tick_q == 4'hF) begin
            state_d = S_DATA;
            bit_d   = 4'd0;
            txd_d   = sh_q[0];
          end
        end
        S_DATA: begin
          if (tick_q == 4'hF) begin
            if (bit_q == LAST_BIT) begin
              stop2_d = 1'b0;
              if (par_en_q) begin
                state_d = S_PAR;
                txd_d   = par_bit_q;
              end else begin
                state_d = S_STOP;
                txd_d   = 1'b1;
              end
            end else begin
              bit_d = bit_q + 4'd1;
              sh_d  = sh_q >> 1;
              txd_d = sh_d[0];
            end
          end
        end
        S_PAR: begin
          if (tick_q == 4'hF) begin
            state_d = S_STOP;
            stop2_d = 1'b0;
            txd_d   = 1'b1;
          end
        end
        S_STOP: begin
          if (tick_q == 4'hF) begin
            if (nstop_q && !stop2_q) begin
              stop2_d = 1'b1;
            end else if (start_ok) begin
              load = 1'b1;
            end else begin
              state_d = S_IDLE;
              de_d    = 1'b0;
              txd_d   = 1'b1;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          de_d    = 1'b0;
          txd_d   = 1'b1;
        end
      endcase
      if (load) begin
        state_d   = S_START;
        tick_d    = 4'd0;
        sh_d      = head;
        par_en_d  = tx.ParEn;
        nstop_d   = tx.NumStop;
        par_bit_d = par_calc;
        txd_d     = 1'b0;
        de_d      = 1'b1;
      end
    end
  end

  assign pop = load;

  // Frame state and registered line outputs; reset aborts any frame with the line at mark.
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      state_q   <= S_IDLE;
      tick_q    <= 4'd0;
      bit_q     <= 4'd0;
      stop2_q   <= 1'b0;
      sh_q      <= '0;
      par_en_q  <= 1'b0;
      nstop_q   <= 1'b0;
      par_bit_q <= 1'b0;
      txd_q     <= 1'b1;
      de_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      stop2_q   <= stop2_d;
      sh_q      <= sh_d;
      par_en_q  <= par_en_d;
      nstop_q   <= nstop_d;
      par_bit_q <= par_bit_d;
      txd_q     <= txd_d;
      de_q      <= de_d;
    end
  end

  assign tx.FF     = full;
  assign tx.EF     = empty;
  assign tx.Cnt    = cnt_q;
  assign tx.OvErr  = ov_q;
  assign tx.TxD    = txd_q;
  assign tx.DE     = de_q;
  assign tx.TxIdle = (state_q == S_IDLE);
  assign tx.CE_16x = ce_q;

endmodule

// File: tb/tb_uart_tx_fifo_brg.sv
// Bench for uart_tx_fifo_brg: stimulus pushes expected frames, a UART RX monitor pops and compares.
// Reference parity and frame lengths come from plain arithmetic on the data and framing settings.
// Directed phases cover reset, latency, parity modes, bursts, overflow, CTS hold and mid-frame reset.
module tb_uart_tx_fifo_brg;
  localparam int W   = 8;
  localparam int D   = 16;
  localparam int DIV = 4;
  localparam int BIT = 16 * DIV;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       pb;
    logic       ns;
  } exp_t;

  logic Clk = 1'b0;
  logic nRst = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   rx_count = 0;
  int   rst_epoch = 0;
  bit   mon_en = 1'b0;
  exp_t exp_q[$];

  uart_tx_fifo_brg_if #(.pWidth(W), .pDepth(D)) u_if ();

  uart_tx_fifo_brg #(.pWidth(W), .pDepth(D), .pBaudDiv(DIV)) dut (
    .Clk  (Clk),
    .nRst (nRst),
    .tx   (u_if.slave)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, want);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timeout", nm);
  endtask

  function automatic logic model_par(input logic [7:0] d, input logic [1:0] mode);
    int ones;
    ones = $countones(d);
    case (mode)
      2'd0:    return (ones % 2 == 0);   // odd parity: total ones made odd
      2'd1:    return (ones % 2 == 1);   // even parity: total ones made even
      2'd2:    return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic int frame_clks(input logic pe, input logic ns);
    return BIT * (1 + W + int'(pe) + 1 + int'(ns));
  endfunction

  task automatic set_cfg(input logic ns, input logic pe, input logic [1:0] par);
    u_if.NumStop = ns;
    u_if.ParEn   = pe;
    u_if.Par     = par;
  endtask

  task automatic wr(input logic [7:0] d, input bit accept);
    exp_t e;
    @(negedge Clk);
    u_if.WE = 1'b1;
    u_if.WD = d;
    if (accept) begin
      e.d  = d;
      e.pe = u_if.ParEn;
      e.pb = model_par(d, u_if.Par);
      e.ns = u_if.NumStop;
      exp_q.push_back(e);
    end
    @(negedge Clk);
    u_if.WE = 1'b0;
  endtask

  task automatic wait_rx(input int target, input int budget, input string nm);
    int i;
    i = 0;
    while (rx_count < target && i < budget) begin
      @(negedge Clk);
      i++;
    end
    if (rx_count < target) timeout(nm);
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int i;
    i = 0;
    while (!(u_if.TxIdle && u_if.EF) && i < budget) begin
      @(negedge Clk);
      i++;
    end
    if (!(u_if.TxIdle && u_if.EF)) timeout(nm);
  endtask

  // Measures DE high time; optionally scrambles framing inputs once the frame has started.
  task automatic de_width(input int want, input bit scramble, input string nm);
    int i;
    int n;
    i = 0;
    n = 0;
    while (!u_if.DE && i < 5000) begin
      @(negedge Clk);
      i++;
    end
    if (!u_if.DE) begin
      timeout(nm);
    end else begin
      if (scramble) set_cfg(1'($urandom), 1'($urandom), 2'($urandom));
      while (u_if.DE && n < 20000) begin
        @(negedge Clk);
        n++;
      end
      chk(nm, n, want);
    end
  endtask

  // UART receiver: samples mid-bit, pops the expected frame at the start bit.
  initial begin
    exp_t e;
    int   ep;
    bit   had;
    logic [7:0] rd;
    logic b;
    logic stop_ok;
    wait (mon_en);
    forever begin
      @(negedge Clk);
      if (nRst && u_if.TxD == 1'b0) begin
        ep  = rst_epoch;
        had = (exp_q.size() != 0);
        if (had) e = exp_q.pop_front();
        else begin
          e.d = 8'h00; e.pe = 1'b0; e.pb = 1'b0; e.ns = 1'b0;
        end
        repeat (BIT / 2) @(negedge Clk);
        b = u_if.TxD;
        rd = 8'h00;
        for (int k = 0; k < W; k++) begin
          repeat (BIT) @(negedge Clk);
          rd[k] = u_if.TxD;
        end
        stop_ok = 1'b1;
        if (e.pe) begin
          repeat (BIT) @(negedge Clk);
          if (ep == rst_epoch && had) chk("rx_parity", u_if.TxD, e.pb);
        end
        repeat (BIT) @(negedge Clk);
        stop_ok &= u_if.TxD;
        if (e.ns) begin
          repeat (BIT) @(negedge Clk);
          stop_ok &= u_if.TxD;
        end
        if (ep == rst_epoch) begin
          if (!had) begin
            chk("rx_unexpected_frame", 1, 0);
          end else begin
            chk("rx_start_bit", b, 1'b0);
            chk("rx_data", rd, e.d);
            chk("rx_stop_bits", stop_ok, 1'b1);
          end
          rx_count++;
        end
      end
    end
  end

  initial begin
    int   n;
    int   lat;
    int   ov;
    int   rx0;
    logic [7:0] burst[13];
    logic [7:0] r;

    u_if.WE = 1'b0;
    u_if.WD = '0;
    u_if.CTSi = 1'b1;
    set_cfg(1'b0, 1'b0, 2'd0);

    // Reset state
    #200;
    chk("rst_txd", u_if.TxD, 1'b1);
    chk("rst_de", u_if.DE, 1'b0);
    chk("rst_ef", u_if.EF, 1'b1);
    chk("rst_ff", u_if.FF, 1'b0);
    chk("rst_cnt", u_if.Cnt, 0);
    chk("rst_overr", u_if.OvErr, 1'b0);
    chk("rst_ce", u_if.CE_16x, 1'b0);
    chk("rst_idle", u_if.TxIdle, 1'b1);
    @(negedge Clk);
    nRst = 1'b1;
    mon_en = 1'b1;

    // BRG period
    for (int p = 0; p < 2; p++) begin
      n = 0;
      while (!u_if.CE_16x && n < 100) begin @(negedge Clk); n++; end
      n = 0;
      do begin @(negedge Clk); n++; end while (!u_if.CE_16x && n < 100);
      chk("ce_period", n, DIV);
    end

    // 8N1 0x55: latency and DE width
    @(negedge Clk);
    u_if.WE = 1'b1;
    u_if.WD = 8'h55;
    exp_q.push_back('{8'h55, 1'b0, 1'b0, 1'b0});
    lat = 1;
    @(negedge Clk);
    u_if.WE = 1'b0;
    while (u_if.TxD && lat < 100) begin @(negedge Clk); lat++; end
    chk("start_latency_in_range", (lat >= 2 && lat <= DIV + 2), 1);
    de_width(frame_clks(1'b0, 1'b0), 1'b0, "de_width_8n1");
    wait_rx(1, 2000, "rx_8n1");

    // Parity modes on 0x7B
    set_cfg(1'b0, 1'b1, 2'd1);
    wr(8'h7B, 1'b1);
    de_width(frame_clks(1'b1, 1'b0), 1'b0, "de_width_even");
    set_cfg(1'b0, 1'b1, 2'd0);
    wr(8'h7B, 1'b1);
    de_width(frame_clks(1'b1, 1'b0), 1'b0, "de_width_odd");
    set_cfg(1'b1, 1'b1, 2'd3);
    wr(8'h7B, 1'b1);
    de_width(frame_clks(1'b1, 1'b1), 1'b0, "de_width_mark_2stop");
    wait_rx(4, 2000, "rx_parity_set");

    // Burst of 13 back-to-back frames
    set_cfg(1'b0, 1'b0, 2'd0);
    burst[0] = 8'hFF; burst[1] = 8'h80; burst[2] = 8'h7B;
    for (int i = 3; i < 11; i++) burst[i] = 8'($urandom_range(0, 255));
    burst[11] = 8'h31; burst[12] = 8'h00;
    rx0 = rx_count;
    for (int i = 0; i < 13; i++) wr(burst[i], 1'b1);
    n = 0;
    while (u_if.TxIdle && n < 100) begin @(negedge Clk); n++; end
    n = 0;
    while (!u_if.TxIdle && n < 13 * frame_clks(1'b1, 1'b1)) begin @(negedge Clk); n++; end
    chk("burst_frames_before_idle", rx_count - rx0, 13);

    // Overflow with CTS held low
    wait_idle(2000, "idle_before_overflow");
    u_if.CTSi = 1'b0;
    ov = 0;
    for (int i = 0; i < 17; i++) begin
      r = 8'($urandom_range(0, 255));
      @(negedge Clk);
      if (u_if.OvErr) ov++;
      u_if.WE = 1'b1;
      u_if.WD = r;
      if (i < D) exp_q.push_back('{r, 1'b0, 1'b0, 1'b0});
      @(negedge Clk);
      if (u_if.OvErr) ov++;
      u_if.WE = 1'b0;
    end
    repeat (3) begin @(negedge Clk); if (u_if.OvErr) ov++; end
    chk("ovf_pulses", ov, 1);
    chk("ovf_ff", u_if.FF, 1'b1);
    chk("ovf_cnt", u_if.Cnt, D);
    chk("ovf_idle_while_cts_low", u_if.TxIdle, 1'b1);
    rx0 = rx_count;
    u_if.CTSi = 1'b1;
    wait_rx(rx0 + D, D * frame_clks(1'b0, 1'b0) + 2000, "rx_overflow_drain");
    wait_idle(2000, "idle_after_drain");
    chk("drain_ef", u_if.EF, 1'b1);

    // CTS drops mid-frame: current frame completes, next is held
    rx0 = rx_count;
    wr(8'hC3, 1'b1);
    wr(8'h3C, 1'b1);
    n = 0;
    while (!u_if.DE && n < 200) begin @(negedge Clk); n++; end
    repeat (BIT * 3) @(negedge Clk);
    u_if.CTSi = 1'b0;
    n = 0;
    while (!u_if.TxIdle && n < 2000) begin @(negedge Clk); n++; end
    repeat (3 * frame_clks(1'b0, 1'b0)) @(negedge Clk);
    chk("cts_hold_frames", rx_count - rx0, 1);
    chk("cts_hold_cnt", u_if.Cnt, 1);
    chk("cts_hold_idle", u_if.TxIdle, 1'b1);
    u_if.CTSi = 1'b1;
    wait_rx(rx0 + 2, 2000, "rx_after_cts");

    // Random framing; inputs scrambled after frame start must not affect it
    for (int i = 0; i < 8; i++) begin
      logic ns;
      logic pe;
      wait_idle(3000, "idle_before_random");
      ns = 1'($urandom);
      pe = 1'($urandom);
      set_cfg(ns, pe, 2'($urandom));
      wr(8'($urandom_range(0, 255)), 1'b1);
      de_width(frame_clks(pe, ns), 1'b1, "de_width_random");
    end
    wait_idle(3000, "idle_after_random");
    repeat (BIT) @(negedge Clk);

    // Reset during DATA
    set_cfg(1'b0, 1'b0, 2'd0);
    wr(8'hA5, 1'b1);
    wr(8'h5A, 1'b1);
    n = 0;
    while (!u_if.DE && n < 200) begin @(negedge Clk); n++; end
    repeat (BIT * 3) @(negedge Clk);
    rst_epoch++;
    exp_q.delete();
    nRst = 1'b0;
    repeat (2) @(negedge Clk);
    chk("midrst_txd", u_if.TxD, 1'b1);
    chk("midrst_de", u_if.DE, 1'b0);
    chk("midrst_ef", u_if.EF, 1'b1);
    chk("midrst_cnt", u_if.Cnt, 0);
    nRst = 1'b1;
    repeat (frame_clks(1'b1, 1'b1)) @(negedge Clk);
    chk("postrst_idle", u_if.TxIdle, 1'b1);
    rx0 = rx_count;
    wr(8'h96, 1'b1);
    wait_rx(rx0 + 1, 2000, "rx_after_reset");
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
